rr_grant_arbiter_4: RTL

- Four-requester round-robin arbiter with hold-and-timeout.
- Its registered 2-bit winner index drives the existing decoder_2to4 stage directly, as decoder input a.
- That decoder's one-hot output, gated by grant-valid, is the per-requester grant.
- Sits upstream of the decoder in the shared-resource select path. It supplies the sequential selection that the decoder only translates.

---
 rtl/rr_grant_arbiter_4_pkg.sv | 31 +++
 rtl/decoder_2to4.sv | 12 +
 rtl/rr_grant_arbiter_4.sv | 97 +++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_4_pkg.sv
// Shared sizes and the round-robin winner helper for the 4-way grant arbiters.
package rr_grant_arbiter_4_pkg;

    localparam int NUM_REQ  = 4;
    localparam int IDX_W    = 2;
    localparam int ONEHOT_W = 4;

    // Arbiter control state: gnt_valid is simply "state == ST_GRANT".
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // First set bit of v scanning p, p+1, p+2, p+3 (mod 4). Scanning from the
    // farthest offset down lets the nearest set bit overwrite the result.
    // Returns p when v is empty; callers only use it with v != 0.
    function automatic logic [IDX_W-1:0] rr_winner(
        input logic [NUM_REQ-1:0] v,
        input logic [IDX_W-1:0]   p
    );
        logic [IDX_W-1:0] cand;
        rr_winner = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = p + IDX_W'(k);
            if (v[cand]) begin
                rr_winner = cand;
            end
        end
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Existing 2-to-4 one-hot decoder used on the shared-resource select path.
module decoder_2to4 (
    input  logic [1:0] a,
    output logic [3:0] y
);

    // Binary index to one-hot select.
    always_comb begin
        y = 4'b0001 << a;
    end

endmodule

// File: rtl/rr_grant_arbiter_4.sv
// Four-requester round-robin arbiter with hold limit. The registered winner
// index feeds decoder_2to4; its one-hot output gated by gnt_valid is the grant.
module rr_grant_arbiter_4
    import rr_grant_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic                gnt_valid,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic [ONEHOT_W-1:0] gnt_onehot,
    output logic                preempt
);

    arb_state_t          state, state_n;
    logic [IDX_W-1:0]    idx_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [CNT_W-1:0]    hold_cnt, hold_cnt_n;
    logic                preempt_n;
    logic                drop, tmo;
    logic [NUM_REQ-1:0]  others;
    logic [ONEHOT_W-1:0] onehot_raw;

    // State registers; reset clears everything, including mid-grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt_idx  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt_idx  <= idx_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
            preempt  <= preempt_n;
        end
    end

    // Next-state: pick a winner from idle, or hold/hand over/regrant/release.
    // Simultaneous drop and timeout counts as a drop, so no preempt pulse.
    always_comb begin
        state_n    = state;
        idx_n      = gnt_idx;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        preempt_n  = 1'b0;
        drop       = !req[gnt_idx];
        tmo        = (hold_cnt == CNT_W'(MAX_HOLD - 1));
        others     = req & ~(NUM_REQ'(1) << gnt_idx);
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_n    = ST_GRANT;
                    idx_n      = rr_winner(req, ptr);
                    hold_cnt_n = '0;
                end
            end
            ST_GRANT: begin
                if (drop || tmo) begin
                    ptr_n      = gnt_idx + IDX_W'(1);
                    hold_cnt_n = '0;
                    preempt_n  = tmo && !drop;
                    if (others != '0) begin
                        idx_n = rr_winner(others, gnt_idx + IDX_W'(1));
                    end else if (tmo && !drop) begin
                        idx_n = gnt_idx;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign gnt_valid = (state == ST_GRANT);

    decoder_2to4 u_dec (
        .a (gnt_idx),
        .y (onehot_raw)
    );

    // Suppress the decoded select whenever no grant is active.
    always_comb begin
        gnt_onehot = onehot_raw & {ONEHOT_W{gnt_valid}};
    end

endmodule
